uart_fifo: RTL and testbench

- Next-generation memory-mapped UART peripheral for the Apple-1 style PIA address window (0xD010-0xD013).
- Adds parametrised RX and TX FIFOs, a sticky RX overrun flag, FIFO-level CTS throttling, a selectable 7/8-bit data path and a TX status register.
- Wraps the existing async_transmitter and async_receiver serial engines; sits between the CPU bus decode and the board UART pins.

---
 rtl/uart_pkg.sv | 17 +
 rtl/async_receiver.sv | 68 ++++++
 rtl/async_transmitter.sv | 48 ++++
 rtl/sync_fifo.sv | 40 ++++
 rtl/uart_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_fifo.sv | 333 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, TX sequencer
// states and status bit positions.
package uart_pkg;
  localparam logic [1:0] UART_RX   = 2'b00;
  localparam logic [1:0] UART_RXCR = 2'b01;
  localparam logic [1:0] UART_TX   = 2'b10;
  localparam logic [1:0] UART_TXCR = 2'b11;

  typedef enum logic [1:0] {IDLE, START, SETTLE, DRAIN} tx_state_e;

  localparam int ST_RX_NONEMPTY = 7;
  localparam int ST_OVERRUN     = 6;
  localparam int ST_TX_FULL     = 7;
  localparam int ST_TX_EMPTY    = 6;
  localparam int ST_TX_BUSY     = 5;
  localparam int CLR_OVERRUN    = 6;
endpackage

// File: rtl/async_receiver.sv
// 8N1 oversampling serial receiver; RxD_idle is low while a frame is in progress.
module async_receiver #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       RxD_idle
);
  localparam int OS_DIV = ClkFrequency / (Baud * Oversampling);

  logic [15:0] div_cnt;
  logic [1:0]  sync;
  logic        rxd_s, tick, busy;
  logic [3:0]  bit_idx;
  logic [7:0]  sub, shreg;

  assign rxd_s    = sync[1];
  assign tick     = (div_cnt == 16'(OS_DIV - 1));
  assign RxD_idle = ~busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync           <= 2'b11;
      div_cnt        <= '0;
      busy           <= 1'b0;
      bit_idx        <= '0;
      sub            <= '0;
      shreg          <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
    end else begin
      sync           <= {sync[0], RxD};
      div_cnt        <= tick ? '0 : div_cnt + 16'd1;
      RxD_data_ready <= 1'b0;
      if (tick) begin
        if (!busy) begin
          // start half a bit ahead so every sample lands near a bit centre
          if (!rxd_s) begin
            busy    <= 1'b1;
            sub     <= 8'(Oversampling / 2);
            bit_idx <= '0;
          end
        end else if (sub == 8'(Oversampling - 1)) begin
          sub     <= '0;
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'd0) begin
            if (rxd_s) busy <= 1'b0;
          end else if (bit_idx == 4'd9) begin
            busy <= 1'b0;
            if (rxd_s) begin
              RxD_data       <= shreg;
              RxD_data_ready <= 1'b1;
            end
          end else begin
            shreg <= {rxd_s, shreg[7:1]};
          end
        end else begin
          sub <= sub + 8'd1;
        end
      end
    end
  end
endmodule

// File: rtl/async_transmitter.sv
// 8N1 serial transmitter; TxD_busy rises the cycle after TxD_start is accepted.
module async_transmitter #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);
  localparam int BIT_DIV = ClkFrequency / Baud;

  logic [15:0] div_cnt;
  logic [3:0]  bits_left;
  logic [7:0]  shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      TxD       <= 1'b1;
      TxD_busy  <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      shreg     <= '0;
    end else if (!TxD_busy) begin
      if (TxD_start) begin
        TxD       <= 1'b0;
        shreg     <= TxD_data;
        bits_left <= 4'd9;
        div_cnt   <= '0;
        TxD_busy  <= 1'b1;
      end
    end else if (div_cnt == 16'(BIT_DIV - 1)) begin
      div_cnt <= '0;
      // bits_left==1 emits the stop bit; 0 means the stop bit has completed
      if (bits_left == 4'd0) begin
        TxD_busy <= 1'b0;
      end else begin
        TxD       <= (bits_left == 4'd1) ? 1'b1 : shreg[0];
        shreg     <= shreg >> 1;
        bits_left <= bits_left - 4'd1;
      end
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit.
// The caller is responsible for not pushing when full / popping when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Push+pop while full writes the slot being vacated; dout is read combinationally.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
endmodule

// File: rtl/uart_fifo.sv
// Apple-1 PIA-window UART with RX/TX FIFOs, sticky overrun, CTS throttling
// and a TX sequencer feeding the serial transmitter.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int ClkFrequency  = 25000000,
  parameter int Baud          = 115200,
  parameter int Oversampling  = 8,
  parameter int RX_DEPTH      = 16,
  parameter int TX_DEPTH      = 16,
  parameter int CTS_MARGIN    = 2,
  parameter int SEVEN_BIT     = 1,
  parameter int SKIP_FIRST_TX = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       uart_cts
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);

  logic           rd_stb, wr_stb, rx_rd, rx_rd_q;
  logic           rx_ready, rx_idle;
  logic [7:0]     rx_data, rx_fifo_q, rx_head;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [RAW:0]   rx_count;
  logic           tx_wr, tx_push, tx_pop, tx_full, tx_empty, tx_start, tx_eng_busy;
  logic [7:0]     tx_wdata, tx_head, tx_byte;
  logic [TAW:0]   tx_level_unused;
  logic           overrun, skip_armed;
  tx_state_e      state, state_nxt;
  logic [7:0]     rd_data;
  logic [3:0]     rx_cnt_sat;
  int             rx_free;

  assign rd_stb = enable & ~w_en;
  assign wr_stb = enable & w_en;

  // one pop per CPU read: act only on the first cycle of an RX read
  assign rx_rd   = rd_stb & (address == UART_RX);
  assign rx_pop  = rx_rd & ~rx_rd_q & ~rx_empty;
  assign rx_push = rx_ready & (~rx_full | rx_pop);
  assign rx_head = rx_empty ? 8'h00 : rx_fifo_q;

  assign tx_wr    = wr_stb & (address == UART_TX);
  assign tx_wdata = (SEVEN_BIT != 0) ? {1'b0, din[6:0]} : din;
  assign tx_push  = tx_wr & ~skip_armed & (~tx_full | tx_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_fifo_q), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop), .din(tx_wdata),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_level_unused)
  );

  async_receiver #(.ClkFrequency(ClkFrequency), .Baud(Baud), .Oversampling(Oversampling)) u_rx (
    .clk(clk), .reset(~reset_n), .RxD(uart_rx), .RxD_data_ready(rx_ready),
    .RxD_data(rx_data), .RxD_idle(rx_idle)
  );

  async_transmitter #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_tx (
    .clk(clk), .reset(~reset_n), .TxD_start(tx_start), .TxD_data(tx_byte),
    .TxD(uart_tx), .TxD_busy(tx_eng_busy)
  );

  always_comb begin
    rx_free    = RX_DEPTH - int'(rx_count);
    rx_cnt_sat = (int'(rx_count) > 15) ? 4'd15 : 4'(rx_count);
  end

  assign uart_cts = ~rx_idle | (rx_free <= CTS_MARGIN);

  always_comb begin
    rd_data = 8'h00;
    unique case (address)
      UART_RX:   rd_data = (SEVEN_BIT != 0) ? {~rx_empty, rx_head[6:0]} : rx_head;
      UART_RXCR: rd_data = {~rx_empty, overrun, 2'b00, rx_cnt_sat};
      UART_TX:   rd_data[ST_TX_FULL] = tx_full;
      UART_TXCR: begin
        rd_data[ST_TX_FULL]  = tx_full;
        rd_data[ST_TX_EMPTY] = tx_empty;
        rd_data[ST_TX_BUSY]  = (state != IDLE);
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    tx_start  = 1'b0;
    unique case (state)
      IDLE: if (!tx_empty) begin
        tx_pop    = 1'b1;
        state_nxt = START;
      end
      START: begin
        tx_start  = 1'b1;
        state_nxt = SETTLE;
      end
      // transmitter busy is registered; give it a cycle before trusting it
      SETTLE: state_nxt = DRAIN;
      DRAIN:  if (!tx_eng_busy) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_byte <= 8'h00;
    end else begin
      state <= state_nxt;
      if (tx_pop) tx_byte <= tx_head;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= 8'h00;
      rx_rd_q    <= 1'b0;
      overrun    <= 1'b0;
      skip_armed <= (SKIP_FIRST_TX != 0);
    end else begin
      dout    <= rd_data;
      rx_rd_q <= rx_rd;
      if (tx_wr) skip_armed <= 1'b0;
      if (wr_stb && (address == UART_RXCR) && din[CLR_OVERRUN]) overrun <= 1'b0;
      // a new overrun wins over a simultaneous clear
      if (rx_ready && rx_full && !rx_pop) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: bus tasks, a serial line driver and a
// line monitor, checked against a queue-based model of the register map.
module tb_uart_fifo;
  localparam int BIT_CLKS = 16;
  localparam logic [1:0] A_RX = 2'b00, A_RXCR = 2'b01, A_TX = 2'b10, A_TXCR = 2'b11;

  logic       clk = 1'b0, reset_n = 1'b0, enable = 1'b0, w_en = 1'b0, uart_rx = 1'b1;
  logic [1:0] address = 2'b00;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       uart_tx, uart_cts;

  int checks = 0, failures = 0;
  logic [7:0] tx_seen[$];
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       ovr_m = 1'b0;

  uart_fifo #(
    .ClkFrequency(1600000), .Baud(100000), .Oversampling(8), .RX_DEPTH(16), .TX_DEPTH(16),
    .CTS_MARGIN(2), .SEVEN_BIT(1), .SKIP_FIRST_TX(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .address(address), .w_en(w_en),
    .din(din), .dout(dout), .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_cts(uart_cts)
  );

  always #5 clk = ~clk;

  // decodes frames on uart_tx by sampling at bit centres
  initial begin : line_mon
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (BIT_CLKS / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CLKS) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BIT_CLKS) @(negedge clk);
      if (uart_tx) tx_seen.push_back(b);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_rx();
    return (rxq.size() == 0) ? 8'h00 : {1'b1, rxq[0][6:0]};
  endfunction

  function automatic logic [7:0] exp_rxcr();
    int n;
    n = rxq.size();
    if (n > 15) n = 15;
    return {rxq.size() != 0, ovr_m, 2'b00, 4'(n)};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); enable = 1'b1; w_en = 1'b1; address = a; din = d;
    @(negedge clk); enable = 1'b0; w_en = 1'b0;
  endtask

  // d is the value dout takes one cycle after the address is presented
  task automatic bus_read(input logic [1:0] a, input int hold, output logic [7:0] d);
    @(negedge clk); enable = 1'b1; w_en = 1'b0; address = a;
    @(negedge clk); d = dout;
    repeat (hold - 1) @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); uart_rx = f[i];
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int budget, output bit ok);
    logic [7:0] d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(A_TXCR, 1, d);
      if (d == 8'h40) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h00 || uart_tx !== 1'b1) begin
      failures++; $display("FAIL reset_outputs dout=%02h tx=%b exp dout=00 tx=1", dout, uart_tx);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      e = (a == 3) ? 8'h40 : 8'h00;
      bus_read(2'(a), 1, d);
      checks++;
      if (d !== e) begin
        failures++; $display("FAIL reset_read addr=%0d got=%02h exp=%02h", a, d, e);
      end
    end
    checks++;
    if (uart_tx !== 1'b1 || uart_cts !== 1'b0) begin
      failures++; $display("FAIL reset_lines tx=%b cts=%b exp tx=1 cts=0", uart_tx, uart_cts);
    end
  endtask

  task automatic test_tx_skip();
    logic [7:0] d;
    bit ok;
    tx_seen.delete();
    bus_write(A_TX, 8'h7F);
    bus_write(A_TX, 8'hC1);
    bus_write(A_TX, 8'h42);
    bus_read(A_TXCR, 1, d);
    checks++;
    if (d[5] !== 1'b1) begin
      failures++; $display("FAIL tx_busy_set got=%02h exp bit5=1", d);
    end
    wait_tx_idle(2000, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL tx_idle_timeout got=not-idle exp=40");
    end
    checks++;
    if (tx_seen.size() != 2 || tx_seen[0] !== 8'h41 || tx_seen[1] !== 8'h42) begin
      failures++;
      $display("FAIL tx_skip_frames got n=%0d first=%02h exp n=2 41,42", tx_seen.size(),
               (tx_seen.size() > 0) ? tx_seen[0] : 8'hxx);
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d, b;
    int n;
    for (int i = 0; i < 3; i++) begin
      b = 8'h31 + 8'(i);
      send_rx(b); rxq.push_back(b);
    end
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== 8'h83) begin
      failures++; $display("FAIL rxcr_three got=%02h exp=83", d);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_RX, 3, d);
      checks++;
      if (d !== exp_rx()) begin
        failures++; $display("FAIL rx_read_%0d got=%02h exp=%02h", i, d, exp_rx());
      end
      void'(rxq.pop_front());
    end
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== exp_rxcr()) begin
      failures++; $display("FAIL rxcr_drained got=%02h exp=%02h", d, exp_rxcr());
    end
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_rx(b); rxq.push_back(b);
    end
    while (rxq.size() != 0) begin
      bus_read(A_RX, $urandom_range(1, 4), d);
      checks++;
      if (d !== exp_rx()) begin
        failures++; $display("FAIL rx_rand_read got=%02h exp=%02h", d, exp_rx());
      end
      void'(rxq.pop_front());
    end
    bus_read(A_RX, 1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL rx_empty_read got=%02h exp=00", d);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d, b;
    logic       cts_e;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_rx(b);
      if (rxq.size() < 16) rxq.push_back(b); else ovr_m = 1'b1;
      cts_e = (16 - rxq.size()) <= 2;
      checks++;
      if (uart_cts !== cts_e) begin
        failures++; $display("FAIL cts_level n=%0d got=%b exp=%b", rxq.size(), uart_cts, cts_e);
      end
    end
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== exp_rxcr()) begin
      failures++; $display("FAIL rxcr_overrun got=%02h exp=%02h", d, exp_rxcr());
    end
    bus_write(A_RXCR, 8'hBF);
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== exp_rxcr()) begin
      failures++; $display("FAIL overrun_kept got=%02h exp=%02h", d, exp_rxcr());
    end
    bus_write(A_RXCR, 8'h40); ovr_m = 1'b0;
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== exp_rxcr()) begin
      failures++; $display("FAIL overrun_clear got=%02h exp=%02h", d, exp_rxcr());
    end
    while (rxq.size() != 0) begin
      bus_read(A_RX, 1, d);
      checks++;
      if (d !== exp_rx()) begin
        failures++; $display("FAIL ovf_drain got=%02h exp=%02h", d, exp_rx());
      end
      void'(rxq.pop_front());
    end
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL ovf_rxcr_end got=%02h exp=00", d);
    end
  endtask

  task automatic test_tx_fill();
    logic [7:0] d, b;
    bit ok;
    tx_seen.delete(); txq.delete();
    b = 8'($urandom);
    bus_write(A_TX, b); txq.push_back({1'b0, b[6:0]});
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      bus_read(A_TXCR, 1, d);
      if (d[5]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL tx_first_start got=idle exp=busy");
    end
    // one byte now lives in the transmitter; the FIFO itself takes 16 more
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      bus_write(A_TX, b); txq.push_back({1'b0, b[6:0]});
    end
    bus_read(A_TX, 1, d);
    checks++;
    if (d !== 8'h80) begin
      failures++; $display("FAIL tx_full_status got=%02h exp=80", d);
    end
    bus_read(A_TXCR, 1, d);
    checks++;
    if (d !== 8'hA0) begin
      failures++; $display("FAIL txcr_full got=%02h exp=A0", d);
    end
    bus_write(A_TX, 8'($urandom));
    wait_tx_idle(4000, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL tx_fill_timeout got=not-idle exp=40");
    end
    checks++;
    if (tx_seen.size() != txq.size()) begin
      failures++; $display("FAIL tx_fill_count got=%0d exp=%0d", tx_seen.size(), txq.size());
    end
    for (int i = 0; i < txq.size() && i < tx_seen.size(); i++) begin
      checks++;
      if (tx_seen[i] !== txq[i]) begin
        failures++; $display("FAIL tx_fill_frame_%0d got=%02h exp=%02h", i, tx_seen[i], txq[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    bit ok;
    send_rx(8'($urandom)); send_rx(8'($urandom));
    for (int i = 0; i < 3; i++) bus_write(A_TX, 8'($urandom));
    repeat (40) @(negedge clk);
    uart_rx = 1'b0;
    repeat (24) @(negedge clk);
    checks++;
    if (uart_cts !== 1'b1) begin
      failures++; $display("FAIL cts_midframe got=%b exp=1", uart_cts);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++; $display("FAIL tx_abort got=%b exp=1", uart_tx);
    end
    repeat (3) @(negedge clk);
    uart_rx = 1'b1; reset_n = 1'b1;
    rxq.delete(); ovr_m = 1'b0;
    repeat (BIT_CLKS * 11) @(negedge clk);
    tx_seen.delete();
    bus_read(A_RXCR, 1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL rst_rxcr got=%02h exp=00", d);
    end
    bus_read(A_TXCR, 1, d);
    checks++;
    if (d !== 8'h40) begin
      failures++; $display("FAIL rst_txcr got=%02h exp=40", d);
    end
    bus_write(A_TX, 8'h11);
    bus_write(A_TX, 8'h22);
    wait_tx_idle(2000, ok);
    checks++;
    if (!ok || tx_seen.size() != 1 || tx_seen[0] !== 8'h22) begin
      failures++;
      $display("FAIL rst_skip_rearm got n=%0d first=%02h exp n=1 22", tx_seen.size(),
               (tx_seen.size() > 0) ? tx_seen[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_tx_skip();
    test_rx_basic();
    test_overflow();
    test_tx_fill();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
